// File: rtl/fdct_pkg.sv
// Shared definitions for the sequential 8-point row FDCT.
// Holds the FSM state encoding, the Q12 cosine table C[u][n]
// (orthonormal DCT-II, rounded half away from zero), and the rounding
// and shift constants of the final scaling step.
package fdct_pkg;

    localparam int unsigned N_PTS     = 8;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned TAB_W     = 13;
    localparam int unsigned RND_CONST = 2048;
    localparam int unsigned RND_SHIFT = 12;

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DRAIN   = 2'd2
    } state_e;

    // C[u][n] = round(4096 * c(u) * cos((2n+1)u*pi/16)), c(0)=1/(2*sqrt2), c(u>0)=1/2
    localparam logic signed [TAB_W-1:0] C_TAB [N_PTS][N_PTS] = '{
        '{ 13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448,  13'sd1448},
        '{ 13'sd2009,  13'sd1703,  13'sd1138,  13'sd400,  -13'sd400,  -13'sd1138, -13'sd1703, -13'sd2009},
        '{ 13'sd1892,  13'sd784,  -13'sd784,  -13'sd1892, -13'sd1892, -13'sd784,   13'sd784,   13'sd1892},
        '{ 13'sd1703, -13'sd400,  -13'sd2009, -13'sd1138,  13'sd1138,  13'sd2009,  13'sd400,  -13'sd1703},
        '{ 13'sd1448, -13'sd1448, -13'sd1448,  13'sd1448,  13'sd1448, -13'sd1448, -13'sd1448,  13'sd1448},
        '{ 13'sd1138, -13'sd2009,  13'sd400,   13'sd1703, -13'sd1703, -13'sd400,   13'sd2009, -13'sd1138},
        '{ 13'sd784,  -13'sd1892,  13'sd1892, -13'sd784,  -13'sd784,   13'sd1892, -13'sd1892,  13'sd784},
        '{ 13'sd400,  -13'sd1138,  13'sd1703, -13'sd2009,  13'sd2009, -13'sd1703,  13'sd1138, -13'sd400}
    };

    // Table lookup for coefficient u, sample n
    function automatic logic signed [TAB_W-1:0] coef(input logic [IDX_W-1:0] u,
                                                      input logic [IDX_W-1:0] n);
        return C_TAB[u][n];
    endfunction

endpackage

// File: rtl/fdct_mac.sv
// Registered multiply-accumulate for the row FDCT.
// Ports:
//   clk, rst  : clock, synchronous active-high reset (clears accumulator)
//   clr       : synchronous accumulator clear (priority over en)
//   en        : accumulate a*b into the accumulator
//   a, b      : signed sample and signed Q12 coefficient
//   result_c  : combinational sat((acc + a*b + RND_CONST) >>> RND_SHIFT)
module fdct_mac
    import fdct_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned COEF_W = TAB_W,
    parameter int unsigned OUT_W  = 18,
    parameter int unsigned ACC_W  = 34
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [COEF_W-1:0] b,
    output logic signed [OUT_W-1:0]  result_c
);

    localparam int unsigned PROD_W = DATA_W + COEF_W;
    localparam logic signed [ACC_W-1:0] RND = ACC_W'(RND_CONST);

    logic signed [PROD_W-1:0]    prod;
    logic signed [ACC_W-1:0]     acc_q;
    logic signed [ACC_W-1:0]     acc_sum;
    logic signed [ACC_W-1:0]     rounded;
    logic signed [ACC_W-1:0]     shifted;
    logic        [ACC_W-OUT_W:0] hi;
    logic                        fits;

    // Full-precision product, sign-extended into the accumulator width
    assign prod    = a * b;
    assign acc_sum = acc_q + ACC_W'(prod);
    assign rounded = acc_sum + RND;
    assign shifted = rounded >>> RND_SHIFT;

    // Result fits OUT_W when all bits above the output sign bit match it
    assign hi   = shifted[ACC_W-1:OUT_W-1];
    assign fits = (&hi) | (~|hi);

    always_comb begin
        result_c = shifted[OUT_W-1:0];
        if (!fits) begin
            result_c = shifted[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                        : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

    // Accumulator register
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_sum;
        end
    end

endmodule

// File: rtl/fdct_row_seq.sv
// Sequential forward 1-D DCT over one 8-sample row (encoder path).
// Loads 8 samples, computes 8 coefficients with one shared MAC
// (8 cycles per coefficient, 64 total), then streams F[0..7] out.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : sample stream handshake, in_data signed sample
//   out_valid/out_ready   : coefficient stream handshake
//   out_data, out_idx     : coefficient F[u] and its index u
//   out_last              : high with u=7
// Optional build macro FDCT_ROW_ZERO_SKIP_EN: an all-zero row skips
// COMPUTE and enters DRAIN straight after the 8th sample (same outputs).
module fdct_row_seq
    import fdct_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned OUT_W  = 18,
    parameter int unsigned COEF_W = TAB_W,
    parameter int unsigned ACC_W  = 34
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [OUT_W-1:0]  out_data,
    output logic [IDX_W-1:0]         out_idx,
    output logic                     out_last
);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PTS - 1);

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        u_q, u_d;
    logic [IDX_W-1:0]        n_q, n_d;
    logic                    in_ready_d;
    logic                    out_valid_d;
    logic signed [OUT_W-1:0] out_data_d;
    logic [IDX_W-1:0]        out_idx_d;
    logic                    out_last_d;
    logic                    x_we;
    logic                    f_we;
    logic                    f_clr;
    logic                    mac_en;
    logic                    mac_clr;
    logic signed [OUT_W-1:0] mac_result;

    logic signed [DATA_W-1:0] x_q [N_PTS];
    logic signed [OUT_W-1:0]  f_q [N_PTS];

`ifdef FDCT_ROW_ZERO_SKIP_EN
    logic zero_q, zero_d, zero_row;

    // Row is still all-zero including the sample being accepted now
    assign zero_row = ((cnt_q == '0) || zero_q) && (in_data == '0);
`endif

    // Shared multiply-accumulate: x[n] * C[u][n]
    fdct_mac #(
        .DATA_W (DATA_W),
        .COEF_W (COEF_W),
        .OUT_W  (OUT_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .clr      (mac_clr),
        .en       (mac_en),
        .a        (x_q[n_q]),
        .b        (COEF_W'(coef(u_q, n_q))),
        .result_c (mac_result)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        u_d         = u_q;
        n_d         = n_q;
        in_ready_d  = in_ready;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        out_idx_d   = out_idx;
        out_last_d  = out_last;
        x_we        = 1'b0;
        f_we        = 1'b0;
        f_clr       = 1'b0;
        mac_en      = 1'b0;
        mac_clr     = 1'b1;
`ifdef FDCT_ROW_ZERO_SKIP_EN
        zero_d      = zero_q;
`endif

        case (state_q)
            ST_LOAD: begin
                in_ready_d = 1'b1;
                if (in_valid && in_ready) begin
                    x_we  = 1'b1;
                    cnt_d = cnt_q + IDX_W'(1);
`ifdef FDCT_ROW_ZERO_SKIP_EN
                    zero_d = zero_row;
`endif
                    if (cnt_q == IDX_LAST) begin
                        in_ready_d = 1'b0;
                        u_d        = '0;
                        n_d        = '0;
`ifdef FDCT_ROW_ZERO_SKIP_EN
                        if (zero_row) begin
                            state_d     = ST_DRAIN;
                            f_clr       = 1'b1;
                            out_valid_d = 1'b1;
                            out_data_d  = '0;
                            out_idx_d   = '0;
                            out_last_d  = 1'b0;
                        end else begin
                            state_d = ST_COMPUTE;
                        end
`else
                        state_d = ST_COMPUTE;
`endif
                    end
                end
            end

            ST_COMPUTE: begin
                in_ready_d = 1'b0;
                mac_clr    = 1'b0;
                if (n_q == IDX_LAST) begin
                    // Last tap: write the rounded sum and restart the accumulator
                    f_we    = 1'b1;
                    mac_clr = 1'b1;
                    n_d     = '0;
                    u_d     = u_q + IDX_W'(1);
                    if (u_q == IDX_LAST) begin
                        state_d     = ST_DRAIN;
                        out_valid_d = 1'b1;
                        out_data_d  = f_q[0];
                        out_idx_d   = '0;
                        out_last_d  = 1'b0;
                    end
                end else begin
                    mac_en = 1'b1;
                    n_d    = n_q + IDX_W'(1);
                end
            end

            ST_DRAIN: begin
                in_ready_d = 1'b0;
                if (out_ready) begin
                    if (out_idx == IDX_LAST) begin
                        state_d     = ST_LOAD;
                        cnt_d       = '0;
                        in_ready_d  = 1'b1;
                        out_valid_d = 1'b0;
                        out_data_d  = '0;
                        out_idx_d   = '0;
                        out_last_d  = 1'b0;
                    end else begin
                        out_idx_d  = out_idx + IDX_W'(1);
                        out_data_d = f_q[IDX_W'(out_idx + IDX_W'(1))];
                        out_last_d = (out_idx == IDX_W'(N_PTS - 2));
                    end
                end
            end

            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_LOAD;
            cnt_q     <= '0;
            u_q       <= '0;
            n_q       <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
`ifdef FDCT_ROW_ZERO_SKIP_EN
            zero_q    <= 1'b1;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            u_q       <= u_d;
            n_q       <= n_d;
            in_ready  <= in_ready_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_idx   <= out_idx_d;
            out_last  <= out_last_d;
`ifdef FDCT_ROW_ZERO_SKIP_EN
            zero_q    <= zero_d;
`endif
        end
    end

    // Sample and coefficient storage; contents are don't-care outside a row
    always_ff @(posedge clk) begin
        if (x_we) begin
            x_q[cnt_q] <= in_data;
        end
        if (f_clr) begin
            for (int i = 0; i < N_PTS; i++) begin
                f_q[i] <= '0;
            end
        end else if (f_we) begin
            f_q[u_q] <= mac_result;
        end
    end

endmodule

// File: tb/tb_fdct_row_seq.sv
// Directed self-checking bench for fdct_row_seq.
module tb_fdct_row_seq;

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] in_data;
    logic               out_valid;
    logic               out_ready;
    logic signed [17:0] out_data;
    logic [2:0]         out_idx;
    logic               out_last;

    int     vectors = 0;
    int     errors  = 0;
    int     row [8];
    longint got [8];

    always #5 clk = ~clk;

    fdct_row_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last)
    );

    // Independent cosine constant: round half away from zero
    function automatic int coef_ref(int u, int n);
        real cu, v;
        cu = (u == 0) ? 1.0 / (2.0 * $sqrt(2.0)) : 0.5;
        v  = 4096.0 * cu * $cos(real'((2 * n + 1) * u) * 3.14159265358979 / 16.0);
        if (v >= 0.0) return $rtoi(v + 0.5);
        else          return -$rtoi(-v + 0.5);
    endfunction

    function automatic longint model(int u);
        longint s;
        s = 0;
        for (int n = 0; n < 8; n++) s += longint'(row[n]) * longint'(coef_ref(u, n));
        s = (s + 2048) >>> 12;
        if (s > 131071)  s = 131071;
        if (s < -131072) s = -131072;
        return s;
    endfunction

    task automatic set_row(input int v);
        for (int i = 0; i < 8; i++) row[i] = v;
    endtask

    // Feed row[] with optional random idle gaps; t_last = time of 8th handshake edge
    task automatic send_row(input int gaps);
        int guard;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            repeat ((gaps > 0) ? $urandom_range(0, gaps) : 0) @(negedge clk);
            in_valid = 1'b1;
            in_data  = 16'(row[i]);
            guard = 0;
            while (!in_ready && guard < 200) begin
                @(negedge clk);
                guard++;
            end
            if (guard >= 200) begin
                vectors++; errors++;
                $display("FAIL send_timeout: in_ready low for %0d cycles, required 1", guard);
                return;
            end
            @(posedge clk);
        end
    endtask

    // Count cycles from the 8th handshake to the edge that samples out_valid
    task automatic wait_valid(input bit junk, input int exp_lat, input string name);
        int k, seen;
        k = 0; seen = 0;
        do begin
            @(negedge clk);
            k++;
            in_valid = junk;
            in_data  = 16'sh5a5a;
            if (in_ready) seen++;
        end while (!out_valid && k < 200);
        vectors++;
        if (k !== exp_lat) begin
            errors++;
            $display("FAIL %s_latency: got %0d cycles, expected %0d", name, k, exp_lat);
        end
        vectors++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL %s_in_ready_busy: in_ready high %0d cycles, expected 0", name, seen);
        end
    endtask

    // Collect 8 coefficients; checks idx/last order and hold stability under stall
    task automatic collect(input bit rnd, input string name);
        int n, guard;
        bit held, rdy;
        logic signed [17:0] pd;
        logic [2:0] pi;
        logic pl;
        n = 0; guard = 0; held = 1'b0;
        pd = '0; pi = '0; pl = 1'b0;
        while (n < 8 && guard < 400) begin
            @(negedge clk);
            guard++;
            if (out_valid) begin
                if (held) begin
                    vectors++;
                    if ({out_data, out_idx, out_last} !== {pd, pi, pl}) begin
                        errors++;
                        $display("FAIL %s_hold: got %0d/%0d/%0d expected %0d/%0d/%0d",
                                 name, out_data, out_idx, out_last, pd, pi, pl);
                    end
                end
                if (out_idx == 3'd7) in_valid = 1'b0;
                rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                out_ready = rdy;
                if (rdy) begin
                    vectors++;
                    if (out_idx !== 3'(n)) begin
                        errors++;
                        $display("FAIL %s_idx: got %0d expected %0d", name, out_idx, n);
                    end
                    vectors++;
                    if (out_last !== (n == 7)) begin
                        errors++;
                        $display("FAIL %s_last: got %0b expected %0b at u=%0d", name, out_last, (n == 7), n);
                    end
                    got[n] = longint'(out_data);
                    n++;
                    held = 1'b0;
                end else begin
                    held = 1'b1;
                    pd = out_data; pi = out_idx; pl = out_last;
                end
            end else begin
                out_ready = 1'b0;
            end
        end
        if (n < 8) begin
            vectors++; errors++;
            $display("FAIL %s_drain_timeout: got %0d coefficients, expected 8", name, n);
        end
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL %s_valid_drop: got %0b expected 0", name, out_valid);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_back_to_load: in_ready %0b expected 1", name, in_ready);
        end
    endtask

    task automatic check_model(input string name);
        longint e;
        for (int u = 0; u < 8; u++) begin
            e = model(u);
            vectors++;
            if (got[u] !== e) begin
                errors++;
                $display("FAIL %s_F%0d: got %0d expected %0d", name, u, got[u], e);
            end
        end
    endtask

    task automatic check_hand(input string name, input int u, input longint e);
        vectors++;
        if (got[u] !== e) begin
            errors++;
            $display("FAIL %s_F%0d: got %0d expected %0d", name, u, got[u], e);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({in_ready, out_valid, out_data, out_idx, out_last} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%0b vld=%0b data=%0d idx=%0d last=%0b, expected all 0",
                     in_ready, out_valid, out_data, out_idx, out_last);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %0b expected 1", in_ready);
        end
    endtask

    task automatic test_dc();
        set_row(100);
        send_row(0);
        wait_valid(1'b0, 65, "dc");
        collect(1'b0, "dc");
        check_hand("dc", 0, 283);
        for (int u = 1; u < 8; u++) check_hand("dc", u, 0);
    endtask

    task automatic test_impulse();
        set_row(0);
        row[0] = 1000;
        send_row(0);
        wait_valid(1'b0, 65, "impulse");
        collect(1'b0, "impulse");
        check_hand("impulse", 0, 354);
        check_hand("impulse", 1, 490);
        check_model("impulse");
    endtask

    task automatic test_extremes();
        set_row(-32768);
        send_row(0);
        wait_valid(1'b0, 65, "neg_full");
        collect(1'b0, "neg_full");
        check_hand("neg_full", 0, -92672);
        check_model("neg_full");
        for (int i = 0; i < 8; i++) row[i] = (i % 2 == 0) ? 32767 : -32767;
        send_row(0);
        wait_valid(1'b0, 65, "alt_full");
        collect(1'b0, "alt_full");
        check_hand("alt_full", 7, 83997);
        check_model("alt_full");
    endtask

    task automatic test_backpressure();
        row = '{-700, 300, 1200, -50, 9000, -3000, 25, 17000};
        send_row(0);
        wait_valid(1'b1, 65, "bp");
        collect(1'b1, "bp");
        check_model("bp");
    endtask

    task automatic test_back_to_back();
        row = '{5, -6, 7, -8, 9000, 12, -13000, 14};
        send_row(0);
        wait_valid(1'b0, 65, "b2b_a");
        collect(1'b0, "b2b_a");
        check_model("b2b_a");
        row = '{-20000, 15000, -3, 0, 77, -1, 30000, -30000};
        send_row(3);
        wait_valid(1'b0, 65, "b2b_gaps");
        collect(1'b1, "b2b_gaps");
        check_model("b2b_gaps");
    endtask

    task automatic test_reset_mid();
        int highs;
        set_row(4321);
        send_row(0);
        repeat (36) @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_valid: got %0b expected 0", out_valid);
        end
        @(negedge clk);
        vectors++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_in_ready: got %0b expected 1", in_ready);
        end
        highs = 0;
        repeat (80) begin
            @(negedge clk);
            if (out_valid) highs++;
        end
        vectors++;
        if (highs !== 0) begin
            errors++;
            $display("FAIL rst_mid_stray_valid: out_valid high %0d cycles, expected 0", highs);
        end
        test_dc();
    endtask

    task automatic test_zero();
        int exp_lat;
`ifdef FDCT_ROW_ZERO_SKIP_EN
        exp_lat = 1;
`else
        exp_lat = 65;
`endif
        set_row(0);
        send_row(0);
        wait_valid(1'b0, exp_lat, "zero");
        collect(1'b1, "zero");
        for (int u = 0; u < 8; u++) check_hand("zero", u, 0);
    endtask

    initial begin
        test_reset();
        test_dc();
        test_impulse();
        test_extremes();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_zero();
        test_dc();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
